// File: rtl/cpr_cart_loader.sv
// cpr_cart_loader: parses a CPR (RIFF "AMS!") cartridge image streamed over
// ioctl and turns every payload byte of chunks cb00..cbNN into a single-byte
// SDRAM write at CART_BASE + page*16 KiB + offset. Tracks which pages were
// written and whether the image as a whole is usable for Plus mode.
//
// Handshakes:
//   host side  - a byte is taken on ioctl_wr only while ioctl_wait is low.
//                ioctl_wait rises with cart_wr and stays high through the
//                cart_ack cycle, so the host sees it low again the cycle after
//                the ack. A strobe while ioctl_wait is high is an overrun.
//   SDRAM side - cart_wr is a one-cycle request. cart_addr/cart_data hold
//                until the matching cart_ack pulse, which arrives at least one
//                cycle after cart_wr. Only one write is ever outstanding.
module cpr_cart_loader #(
   parameter logic [22:0] CART_BASE = 23'h200000,
   parameter logic [7:0]  CPR_INDEX = 8'd5,
   parameter int          MAX_PAGES = 32
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_index,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        cart_wr,
   output logic [22:0] cart_addr,
   output logic [7:0]  cart_data,
   input  logic        cart_ack,
   output logic [31:0] page_map,
   output logic        plus_valid,
   output logic        cpr_error,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_RIFF_ID, S_RIFF_SIZE, S_FORM_ID, S_CHUNK_ID, S_CHUNK_SIZE,
      S_CHUNK_DATA, S_CHUNK_PAD, S_ERROR, S_FINISH, S_DONE
   } state_t;

   // state is the parser position; checkers can bind to it directly.
   state_t      state, state_n;
   logic        act_q;       // previous Active, reset high so a reset mid-download needs a fresh rise
   logic [1:0]  bc;          // byte index inside 4-byte header/id/size fields
   logic [23:0] id;          // last three chunk id bytes
   logic [31:0] sz;          // remaining chunk payload bytes
   logic        odd;         // chunk size was odd, pad byte follows
   logic [4:0]  pg;          // page of the current chunk
   logic        writable;    // current chunk targets a valid page
   logic [14:0] off;         // bit 14 set once the 16 KiB page is full
   logic        hdr_end;     // download ended while still inside the RIFF header

   logic        active, rise, fall_run, parsing, take, overrun, in_header;
   logic [31:0] hdr_word;
   logic [7:0]  exp_char;
   logic [7:0]  d1;
   logic [6:0]  pg_calc;
   logic        digits_ok, id_ok, wr_ok;
   logic [31:0] sz_full;

   assign active    = ioctl_download & (ioctl_index == CPR_INDEX);
   assign rise      = active & ~act_q;
   assign fall_run  = ~active & act_q & (state != S_IDLE) & (state != S_DONE) & (state != S_FINISH);
   assign parsing   = state inside {S_RIFF_ID, S_RIFF_SIZE, S_FORM_ID, S_CHUNK_ID,
                                    S_CHUNK_SIZE, S_CHUNK_DATA, S_CHUNK_PAD};
   assign take      = parsing & active & ioctl_wr & ~ioctl_wait;
   assign overrun   = parsing & active & ioctl_wr & ioctl_wait;
   assign in_header = state inside {S_RIFF_ID, S_RIFF_SIZE, S_FORM_ID};

   // Header magic character expected at the current byte position.
   assign hdr_word  = (state == S_FORM_ID) ? "AMS!" : "RIFF";
   assign exp_char  = hdr_word[{~bc, 3'b000} +: 8];

   // Chunk id "cbNN" decode, evaluated as the fourth id byte arrives.
   assign d1        = id[7:0];
   assign digits_ok = (d1 >= 8'h30) && (d1 <= 8'h39) && (ioctl_dout >= 8'h30) && (ioctl_dout <= 8'h39);
   assign pg_calc   = {3'b000, d1[3:0]} * 7'd10 + {3'b000, ioctl_dout[3:0]};
   assign id_ok     = (id[23:16] == 8'h63) && (id[15:8] == 8'h62) && digits_ok &&
                      (int'(pg_calc) < MAX_PAGES);
   assign sz_full   = {ioctl_dout, sz[31:8]};
   assign wr_ok     = writable & ~off[14];

   // Parser state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_n;
   end

   // Next-state: new download, end of download, overrun, then per-byte parsing.
   always_comb begin
      state_n = state;
      if (rise) begin
         state_n = S_RIFF_ID;
      end else if (fall_run) begin
         state_n = S_FINISH;
      end else if (state == S_FINISH) begin
         if (!ioctl_wait) state_n = S_DONE;
      end else if (overrun) begin
         state_n = S_ERROR;
      end else if (take) begin
         case (state)
            S_RIFF_ID:    if (ioctl_dout != exp_char) state_n = S_ERROR;
                          else if (bc == 2'd3)        state_n = S_RIFF_SIZE;
            S_RIFF_SIZE:  if (bc == 2'd3)             state_n = S_FORM_ID;
            S_FORM_ID:    if (ioctl_dout != exp_char) state_n = S_ERROR;
                          else if (bc == 2'd3)        state_n = S_CHUNK_ID;
            S_CHUNK_ID:   if (bc == 2'd3)             state_n = S_CHUNK_SIZE;
            S_CHUNK_SIZE: if (bc == 2'd3)             state_n = (sz_full == 32'd0) ? S_CHUNK_ID : S_CHUNK_DATA;
            S_CHUNK_DATA: if (sz == 32'd1)            state_n = odd ? S_CHUNK_PAD : S_CHUNK_ID;
            S_CHUNK_PAD:                              state_n = S_CHUNK_ID;
            default: ;
         endcase
      end
   end

   // Field capture, SDRAM write issue, host stall and status outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         act_q      <= 1'b1;
         bc         <= 2'd0;
         id         <= 24'd0;
         sz         <= 32'd0;
         odd        <= 1'b0;
         pg         <= 5'd0;
         writable   <= 1'b0;
         off        <= 15'd0;
         hdr_end    <= 1'b0;
         cart_wr    <= 1'b0;
         cart_addr  <= 23'd0;
         cart_data  <= 8'd0;
         ioctl_wait <= 1'b0;
         page_map   <= 32'd0;
         plus_valid <= 1'b0;
         cpr_error  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         act_q   <= active;
         cart_wr <= 1'b0;
         if (cart_ack) ioctl_wait <= 1'b0;
         if (rise) begin
            page_map   <= 32'd0;
            plus_valid <= 1'b0;
            cpr_error  <= 1'b0;
            busy       <= 1'b1;
            bc         <= 2'd0;
         end else if (fall_run) begin
            hdr_end <= in_header;
         end else if (state == S_FINISH) begin
            if (!ioctl_wait) begin
               plus_valid <= ~cpr_error & page_map[0] & ~hdr_end;
               busy       <= 1'b0;
            end
         end else if (overrun) begin
            cpr_error <= 1'b1;
         end else if (take) begin
            if (state_n == S_ERROR) cpr_error <= 1'b1;
            if (state inside {S_RIFF_ID, S_RIFF_SIZE, S_FORM_ID, S_CHUNK_ID, S_CHUNK_SIZE})
               bc <= bc + 2'd1;
            case (state)
               S_CHUNK_ID: begin
                  id <= {id[15:0], ioctl_dout};
                  if (bc == 2'd3) begin
                     writable <= id_ok;
                     pg       <= pg_calc[4:0];
                  end
               end
               S_CHUNK_SIZE: begin
                  sz  <= sz_full;
                  off <= 15'd0;
                  if (bc == 2'd3) odd <= sz[8];
               end
               S_CHUNK_DATA: begin
                  sz <= sz - 32'd1;
                  if (wr_ok) begin
                     cart_wr      <= 1'b1;
                     ioctl_wait   <= 1'b1;
                     cart_addr    <= CART_BASE + {4'b0000, pg, off[13:0]};
                     cart_data    <= ioctl_dout;
                     page_map[pg] <= 1'b1;
                     off          <= off + 15'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
